// File: rtl/float_mul_pipe.sv
// ---------------------------------------------------------------------------
// float_mul_pipe
//
// Three-stage pipelined floating-point multiplier for a parameterised
// IEEE-754-style format {sign, exponent, mantissa}. Subnormal inputs are
// flushed to signed zero and results that would be subnormal are flushed to
// signed zero with the underflow flag. Rounding is round-to-nearest,
// ties-to-even.
//
//   S1  decode operands and classify the special cases
//   S2  multiply significands, add exponents
//   S3  normalise, round, pack (this stage is the output register)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair present
//   in_ready   pair accepted this cycle when in_valid is also high
//   float_a    operand A
//   float_b    operand B
//   out_valid  product present
//   out_ready  consumer accepts the product this cycle
//   product    result word, zero while out_valid is low
//   flags      {invalid, overflow, underflow}, zero while out_valid is low
// ---------------------------------------------------------------------------
module float_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   float_a,
    input  logic [EXP_W+MAN_W:0]   float_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   product,
    output logic [2:0]             flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int EW2 = EXP_W + 2;

    localparam logic [EXP_W-1:0]       EXP_ONES = '1;
    localparam logic signed [EW2-1:0]  BIAS     = EW2'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0]  EXP_MAX  = $signed({2'b00, EXP_ONES});
    localparam logic signed [EW2-1:0]  EXP_ZERO = '0;
    localparam logic [W-1:0]           QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Operand class carried down the pipe; anything other than CLS_NORMAL
    // bypasses the arithmetic result in S3.
    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_e;

    // -----------------------------------------------------------------------
    // Flow control: a single global enable. When the output word is held by
    // the consumer every stage freezes, otherwise everything (bubbles
    // included) moves forward one stage.
    // -----------------------------------------------------------------------
    logic stall;
    logic advance;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall;

    // -----------------------------------------------------------------------
    // S1: field extraction and classification
    // -----------------------------------------------------------------------
    logic                sign_a;
    logic                sign_b;
    logic [EXP_W-1:0]    exp_a;
    logic [EXP_W-1:0]    exp_b;
    logic [MAN_W-1:0]    man_a;
    logic [MAN_W-1:0]    man_b;
    logic                a_zero;
    logic                b_zero;
    logic                a_inf;
    logic                b_inf;
    logic                a_nan;
    logic                b_nan;
    logic                a_snan;
    logic                b_snan;
    cls_e                cls_d;
    logic                invalid_d;

    assign sign_a = float_a[W-1];
    assign sign_b = float_b[W-1];
    assign exp_a  = float_a[W-2 -: EXP_W];
    assign exp_b  = float_b[W-2 -: EXP_W];
    assign man_a  = float_a[MAN_W-1:0];
    assign man_b  = float_b[MAN_W-1:0];

    // exp==0 covers both true zero and subnormals, which are flushed to zero.
    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);
    assign a_inf  = (exp_a == EXP_ONES) && (man_a == '0);
    assign b_inf  = (exp_b == EXP_ONES) && (man_b == '0);
    assign a_nan  = (exp_a == EXP_ONES) && (man_a != '0);
    assign b_nan  = (exp_b == EXP_ONES) && (man_b != '0);
    assign a_snan = a_nan && !man_a[MAN_W-1];
    assign b_snan = b_nan && !man_b[MAN_W-1];

    // NaN has priority over everything; inf x zero is the only invalid
    // operation that does not start from a NaN.
    always_comb begin
        cls_d     = CLS_NORMAL;
        invalid_d = 1'b0;
        if (a_nan || b_nan) begin
            cls_d     = CLS_NAN;
            invalid_d = a_snan || b_snan;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            cls_d     = CLS_NAN;
            invalid_d = 1'b1;
        end else if (a_inf || b_inf) begin
            cls_d = CLS_INF;
        end else if (a_zero || b_zero) begin
            cls_d = CLS_ZERO;
        end
    end

    logic                s1_valid;
    logic                s1_sign;
    cls_e                s1_cls;
    logic                s1_invalid;
    logic [EXP_W-1:0]    s1_exp_a;
    logic [EXP_W-1:0]    s1_exp_b;
    logic [SW-1:0]       s1_sig_a;
    logic [SW-1:0]       s1_sig_b;

    // S1 register: the hidden bit is attached here so S2 is a plain multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_cls     <= CLS_ZERO;
            s1_invalid <= 1'b0;
            s1_exp_a   <= '0;
            s1_exp_b   <= '0;
            s1_sig_a   <= '0;
            s1_sig_b   <= '0;
        end else if (advance) begin
            s1_valid   <= in_valid;
            s1_sign    <= sign_a ^ sign_b;
            s1_cls     <= cls_d;
            s1_invalid <= invalid_d;
            s1_exp_a   <= exp_a;
            s1_exp_b   <= exp_b;
            s1_sig_a   <= {1'b1, man_a};
            s1_sig_b   <= {1'b1, man_b};
        end
    end

    // -----------------------------------------------------------------------
    // S2: significand product and biased exponent sum. The exponent is kept
    // two bits wider than the field and signed so that neither the overflow
    // side nor the negative underflow side can wrap.
    // -----------------------------------------------------------------------
    logic [PW-1:0]          mul_full;
    logic signed [EW2-1:0]  exp_sum;

    assign mul_full = PW'(s1_sig_a) * PW'(s1_sig_b);
    assign exp_sum  = $signed({2'b00, s1_exp_a}) + $signed({2'b00, s1_exp_b}) - BIAS;

    logic                   s2_valid;
    logic                   s2_sign;
    cls_e                   s2_cls;
    logic                   s2_invalid;
    logic signed [EW2-1:0]  s2_exp;
    logic [PW-1:0]          s2_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_cls     <= CLS_ZERO;
            s2_invalid <= 1'b0;
            s2_exp     <= '0;
            s2_prod    <= '0;
        end else if (advance) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_cls     <= s1_cls;
            s2_invalid <= s1_invalid;
            s2_exp     <= exp_sum;
            s2_prod    <= mul_full;
        end
    end

    // -----------------------------------------------------------------------
    // S3: normalise, round, pack
    //
    // The product of two significands in [1,2) lies in [1,4). When the top
    // bit is set the value is in [2,4): keep it and bump the exponent,
    // otherwise shift left by one. Either way the leading one then sits at
    // bit PW-1 and is dropped, leaving the fraction in norm_frac.
    // -----------------------------------------------------------------------
    logic [PW-2:0]          norm_frac;
    logic signed [EW2-1:0]  exp_norm;
    logic [MAN_W-1:0]       mant_trunc;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [MAN_W:0]         mant_sum;
    logic signed [EW2-1:0]  exp_rnd;
    logic [W-1:0]           pack_d;
    logic [2:0]             flags_d;

    assign norm_frac  = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    assign exp_norm   = s2_exp + $signed({{(EW2-1){1'b0}}, s2_prod[PW-1]});
    assign mant_trunc = norm_frac[PW-2 -: MAN_W];
    assign guard      = norm_frac[PW-2-MAN_W];
    assign sticky     = |norm_frac[PW-3-MAN_W:0];

    // Ties go to the even mantissa; a carry out of the mantissa means the
    // value rounded up to the next power of two, so the fraction is zero.
    assign round_up   = guard && (sticky || mant_trunc[0]);
    assign mant_sum   = {1'b0, mant_trunc} + {{MAN_W{1'b0}}, round_up};
    assign exp_rnd    = exp_norm + $signed({{(EW2-1){1'b0}}, mant_sum[MAN_W]});

    always_comb begin
        pack_d  = '0;
        flags_d = 3'b000;
        case (s2_cls)
            CLS_NAN: begin
                pack_d  = QNAN;
                flags_d = {s2_invalid, 2'b00};
            end
            CLS_INF: begin
                pack_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            end
            CLS_ZERO: begin
                pack_d = {s2_sign, {(W-1){1'b0}}};
            end
            default: begin
                if (exp_rnd >= EXP_MAX) begin
                    pack_d  = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
                    flags_d = 3'b010;
                end else if (exp_rnd <= EXP_ZERO) begin
                    pack_d  = {s2_sign, {(W-1){1'b0}}};
                    flags_d = 3'b001;
                end else begin
                    pack_d = {s2_sign, exp_rnd[EXP_W-1:0], mant_sum[MAN_W-1:0]};
                end
            end
        endcase
    end

    // Output register. Bubbles load zeros so product and flags read 0
    // whenever out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
            flags     <= 3'b000;
        end else if (advance) begin
            out_valid <= s2_valid;
            product   <= s2_valid ? pack_d : '0;
            flags     <= s2_valid ? flags_d : 3'b000;
        end
    end

endmodule
